data_pack_nway: RTL
===================

Name: data_pack_nway

Overview:
- Per-channel N:1 beat packer between the DDR AXI read channels and the input-buffer write port.
- Each channel collects PACK_RATIO consecutive DATA_WIDTH beats into one PACK_RATIO*DATA_WIDTH word.
- Adds to the fixed 2:1 packer: configurable ratio, real valid/ready backpressure per channel, zero-filled pad mode, and flush of partial packs.

Parameters:
- CHNL, 8, number of independent AXI channels.
- DATA_WIDTH, 256, bits per input beat.
- PACK_RATIO, 2, beats per output word; power of two, 1..8.
- CW, $clog2(PACK_RATIO+1), width of the lane-count field. Derived, not overridable.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- is_pad  in  1  pad mode; each beat is emitted alone with its upper lanes zeroed.
- flush  in  1  single-cycle pulse; requests emission of all partial packs.
- up_dat  in  CHNL*DATA_WIDTH  input beats; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- up_vld  in  CHNL  per-channel input valid.
- up_rdy  out  CHNL  per-channel input ready.
- dn_dat  out  CHNL*PACK_RATIO*DATA_WIDTH  packed words; channel i occupies slice i.
- dn_cnt  out  CHNL*CW  number of populated lanes in each packed word (1..PACK_RATIO).
- dn_vld  out  CHNL  per-channel output valid.
- dn_rdy  in  CHNL  per-channel output ready.
- flush_busy  out  1  high while any channel has an unserved flush request.

Behaviour:
- Timing: one clock, clk. Reset is synchronous and active-high (rst). All state is sampled on the rising edge of clk.
- Reset values: dn_vld=0, dn_dat=0, dn_cnt=0, flush_busy=0, all accumulators and lane counters cleared, flush requests cleared. up_rdy=1 in the first cycle after reset.
- Reset mid-operation drops partial packs and pending outputs without emitting them.
- Channels are fully independent. The only shared inputs are is_pad and flush.
- Transfers: an input beat is accepted when up_vld[i]&up_rdy[i]. An output word is consumed when dn_vld[i]&dn_rdy[i].
- Output slot: one register per channel. The slot is "free" when dn_vld[i]=0 or dn_rdy[i]=1.
- Ready rule: up_rdy[i] = slot free, except it is 0 in the one-cycle close-out described below. up_rdy never depends on up_vld.
- Normal mode: the beat accepted with lane counter k is written to lane k (the LSB lane is the oldest), then k increments.
  - When k reaches PACK_RATIO-1 on acceptance, the full word moves to the output slot: dn_vld[i]=1 the next cycle, dn_cnt=PACK_RATIO, and k wraps to 0.
  - Latency from the last beat accepted to dn_vld is 1 cycle. Sustained throughput is one beat per cycle.
- Pad mode (is_pad=1 at acceptance): the beat goes to lane 0, all other lanes are 0, dn_cnt=1, and it is emitted next cycle.
- Mode switch with k>0: if an accepted pad beat would arrive while k>0, the channel performs a one-cycle close-out first.
  - In the close-out cycle up_rdy[i]=0, and the partial pack is emitted zero-filled with dn_cnt=k.
  - The pad beat is accepted in a later cycle.
- Flush: a flush pulse sets a request in every channel with k>0. A channel with k=0 ignores the pulse.
  - A pending request emits the partial pack (zero-filled, dn_cnt=k) in the first cycle where the slot is free and no beat is accepted; it then clears the request and k.
  - If a beat is accepted in the same cycle, the beat is packed first. If that beat completes the word, the request is cleared with no extra emission.
- flush_busy = OR of the per-channel requests.
- PACK_RATIO=1: a pure per-channel register slice with dn_cnt=1. Flush and close-out never trigger.
- Stall: while dn_vld[i]=1 and dn_rdy[i]=0, dn_dat and dn_cnt for channel i hold stable and up_rdy[i]=0.
- Lane zeroing: lanes not written in the current pack read as 0 on dn_dat. Stale data never leaks.

Decomposition:
- Package data_pack_pkg:
  - function clog2;
  - localparam range checks (PACK_RATIO a power of two, at most 8);
  - typedef for the lane counter;
  - enum for lane FSM states: ACCUM, CLOSE, FLUSH_WAIT.
- Sub-module data_pack_lane: one channel. It holds the accumulator, lane counter, output slot and flush request.
- Top: a generate loop over CHNL lanes, slice wiring, and the OR-reduction for flush_busy.

Test Plan (CHNL=2, DATA_WIDTH=8, PACK_RATIO=4 unless noted):
- Normal pack: ch0 beats 0x11,0x22,0x33,0x44 on consecutive cycles, dn_rdy=1 -> one cycle after 0x44: dn_dat ch0=0x44332211, dn_cnt=4, dn_vld[0] a 1-cycle pulse; ch1 stays idle.
- Backpressure: dn_rdy[0]=0 for 5 cycles after a full word -> dn_dat holds, up_rdy[0]=0 throughout; after release the next 4 beats pack correctly with no loss or duplication.
- Flush: ch0 beats 0xA1,0xA2, then a flush pulse -> dn_dat=0x0000A2A1, dn_cnt=2, flush_busy high for exactly 1 cycle; ch1 (k=0) emits nothing.
- Flush collision: flush in the same cycle as beat 4 of a word -> exactly one word 0x44332211 with dn_cnt=4, no extra zero word.
- Pad switch: 3 beats 0x01,0x02,0x03, then is_pad=1 with beat 0x0F -> close-out word 0x00030201 (dn_cnt=3), up_rdy low 1 cycle, then 0x0000000F with dn_cnt=1.
- Reset mid-pack: rst asserted after 2 beats -> no emission, dn_vld=0; the next 4 beats form a clean word.

Source files
------------

// File: rtl/data_pack_pkg.sv
// Shared types and constant helpers for the N:1 per-channel beat packer.
package data_pack_pkg;

  localparam int MAX_PACK_RATIO = 8;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Legal ratios are powers of two from 1 to MAX_PACK_RATIO.
  function automatic bit ratio_ok(input int ratio);
    return (ratio >= 1) && (ratio <= MAX_PACK_RATIO) && ((ratio & (ratio - 1)) == 0);
  endfunction

  localparam int LANE_CNT_W = clog2(MAX_PACK_RATIO + 1);

  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

  typedef enum logic [1:0] {
    ACCUM      = 2'd0,
    CLOSE      = 2'd1,
    FLUSH_WAIT = 2'd2
  } lane_state_e;

endpackage

// File: rtl/data_pack_lane.sv
// One packer channel: accumulator, lane counter, output slot and flush request.
module data_pack_lane
  import data_pack_pkg::*;
#(
  parameter  int DATA_WIDTH = 256,
  parameter  int PACK_RATIO = 2,
  localparam int CW         = clog2(PACK_RATIO + 1),
  localparam int PW         = PACK_RATIO * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  is_pad_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] up_dat_i,
  input  logic                  up_vld_i,
  output logic                  up_rdy_o,
  output logic [PW-1:0]         dn_dat_o,
  output logic [CW-1:0]         dn_cnt_o,
  output logic                  dn_vld_o,
  input  logic                  dn_rdy_i,
  output logic                  flush_req_o
);

  lane_cnt_t   k_q, k_d;
  lane_state_e state_q, state_d, mode;
  logic [PW-1:0] acc_q, acc_d, acc_w;
  logic [PW-1:0] dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vld_q, vld_d;
  logic          slot_free, close_now, accept;

  // Invariant: lanes at or above k_q in acc_q are always zero, so partial
  // emissions come out zero-filled without extra masking.
  always_comb begin
    slot_free = !vld_q || dn_rdy_i;
    close_now = is_pad_i && (k_q != '0);
    mode      = close_now ? CLOSE : state_q;
    up_rdy_o  = slot_free && !close_now;
    accept    = up_vld_i && up_rdy_o;

    acc_w = acc_q;
    for (int l = 0; l < PACK_RATIO; l++) begin
      if (k_q == lane_cnt_t'(l)) acc_w[l*DATA_WIDTH +: DATA_WIDTH] = up_dat_i;
    end

    k_d     = k_q;
    acc_d   = acc_q;
    state_d = state_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    vld_d   = slot_free ? 1'b0 : vld_q;

    if (flush_i && (k_q != '0)) state_d = FLUSH_WAIT;

    case (mode)
      CLOSE: begin
        if (slot_free) begin
          dat_d   = acc_q;
          cnt_d   = CW'(k_q);
          vld_d   = 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        if (accept) begin
          if (is_pad_i) begin
            dat_d = PW'(up_dat_i);
            cnt_d = CW'(1);
            vld_d = 1'b1;
          end else if (k_q == lane_cnt_t'(PACK_RATIO - 1)) begin
            dat_d   = acc_w;
            cnt_d   = CW'(PACK_RATIO);
            vld_d   = 1'b1;
            k_d     = '0;
            acc_d   = '0;
            state_d = ACCUM;
          end else begin
            acc_d = acc_w;
            k_d   = k_q + lane_cnt_t'(1);
          end
        end else if ((state_q == FLUSH_WAIT) && slot_free) begin
          dat_d   = acc_q;
          cnt_d   = CW'(k_q);
          vld_d   = 1'b1;
          k_d     = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q     <= '0;
      state_q <= ACCUM;
      acc_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      k_q     <= k_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign dn_dat_o    = dat_q;
  assign dn_cnt_o    = cnt_q;
  assign dn_vld_o    = vld_q;
  assign flush_req_o = (state_q == FLUSH_WAIT);

endmodule

// File: rtl/data_pack_nway.sv
// Per-channel N:1 beat packer: CHNL independent lanes sharing pad-mode and flush.
module data_pack_nway
  import data_pack_pkg::*;
#(
  parameter  int CHNL       = 8,
  parameter  int DATA_WIDTH = 256,
  parameter  int PACK_RATIO = 2,
  localparam int CW         = clog2(PACK_RATIO + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 is_pad,
  input  logic                                 flush,
  input  logic [CHNL*DATA_WIDTH-1:0]           up_dat,
  input  logic [CHNL-1:0]                      up_vld,
  output logic [CHNL-1:0]                      up_rdy,
  output logic [CHNL*PACK_RATIO*DATA_WIDTH-1:0] dn_dat,
  output logic [CHNL*CW-1:0]                   dn_cnt,
  output logic [CHNL-1:0]                      dn_vld,
  input  logic [CHNL-1:0]                      dn_rdy,
  output logic                                 flush_busy
);

  localparam int PW = PACK_RATIO * DATA_WIDTH;

  if (!ratio_ok(PACK_RATIO)) begin : g_bad_ratio
    $error("data_pack_nway: PACK_RATIO must be a power of two between 1 and 8");
  end

  logic [CHNL-1:0] flush_req;

  genvar gi;
  for (gi = 0; gi < CHNL; gi++) begin : g_lane
    data_pack_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .PACK_RATIO (PACK_RATIO)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .is_pad_i    (is_pad),
      .flush_i     (flush),
      .up_dat_i    (up_dat[gi*DATA_WIDTH +: DATA_WIDTH]),
      .up_vld_i    (up_vld[gi]),
      .up_rdy_o    (up_rdy[gi]),
      .dn_dat_o    (dn_dat[gi*PW +: PW]),
      .dn_cnt_o    (dn_cnt[gi*CW +: CW]),
      .dn_vld_o    (dn_vld[gi]),
      .dn_rdy_i    (dn_rdy[gi]),
      .flush_req_o (flush_req[gi])
    );
  end

  assign flush_busy = |flush_req;

endmodule
